// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC branch encodings: group codes, function codes, flag bit positions
// and the decoded branch kind used by the branch/PC unit.
package kgp_risc_pkg;

    localparam logic [1:0] BC_REG  = 2'b00;
    localparam logic [1:0] BC_UNC  = 2'b01;
    localparam logic [1:0] BC_BL   = 2'b10;
    localparam logic [1:0] BC_NONE = 2'b11;

    localparam logic [5:0] FN_BR   = 6'd0;
    localparam logic [5:0] FN_BLTZ = 6'd1;
    localparam logic [5:0] FN_BZ   = 6'd2;
    localparam logic [5:0] FN_BNZ  = 6'd3;
    localparam logic [5:0] FN_B    = 6'd0;
    localparam logic [5:0] FN_BCY  = 6'd1;
    localparam logic [5:0] FN_BNCY = 6'd2;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_W = 3;

    // Conditional branches resolve to BK_JUMP or BK_NONE during decode
    typedef enum logic [1:0] {
        BK_NONE = 2'd0,
        BK_JUMP = 2'd1,
        BK_BR   = 2'd2,
        BK_BL   = 2'd3
    } branch_kind_e;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/ALU-side bus of the branch/PC unit: instruction and flag inputs,
// fetch address, link address, RAS status and taken-branch count outputs.
interface branch_pc_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              i_stall;
    logic              i_ins_valid;
    logic [1:0]        i_branch_control_signal;
    logic [5:0]        i_ins_func_code;
    logic [2:0]        i_alu_flag;
    logic              i_flag_we;
    logic [ADDR_W-1:0] i_dest_addr;
    logic [ADDR_W-1:0] i_reg1;
    logic [ADDR_W-1:0] o_pc_out;
    logic [ADDR_W-1:0] o_ref;
    logic              o_taken;
    logic [ADDR_W-1:0] o_ras_top;
    logic              o_ras_empty;
    logic              o_ras_full;
    logic              o_ras_hit;
    logic [CNT_W-1:0]  o_taken_count;

    modport master (
        output i_stall, i_ins_valid, i_branch_control_signal, i_ins_func_code,
               i_alu_flag, i_flag_we, i_dest_addr, i_reg1,
        input  o_pc_out, o_ref, o_taken, o_ras_top, o_ras_empty, o_ras_full,
               o_ras_hit, o_taken_count
    );

    modport slave (
        input  i_stall, i_ins_valid, i_branch_control_signal, i_ins_func_code,
               i_alu_flag, i_flag_we, i_dest_addr, i_reg1,
        output o_pc_out, o_ref, o_taken, o_ras_top, o_ras_empty, o_ras_full,
               o_ras_hit, o_taken_count
    );

endinterface

// File: rtl/branch_ras.sv
// Return-address stack as a circular buffer: push on a full stack overwrites the
// oldest entry, pop on an empty stack is ignored, top reads 0 when empty.
module branch_ras #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned OCC_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [PTR_W-1:0]  w_top_idx;

    // r_ptr is the next write slot; the newest entry sits just below it
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign empty     = (r_occ == '0);
    assign full      = (r_occ == OCC_W'(RAS_DEPTH));
    assign top       = empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_occ <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!full) r_occ <= r_occ + OCC_W'(1);
        end else if (pop && !empty) begin
            r_ptr <= w_top_idx;
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_pc_unit.sv
// KGP-RISC branch/PC unit: flag register, branch decode against registered flags,
// next-PC mux, PC register, return-address stack and saturating taken counter.
module branch_pc_unit
    import kgp_risc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    branch_pc_unit_if.slave io_bus
);
    logic [FLAG_W-1:0] r_flags;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_cnt;
    branch_kind_e      w_kind;
    logic              w_taken;
    logic [ADDR_W-1:0] w_ref;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;

    // Branch decode; flags come from the register, never straight from the ALU
    always_comb begin
        w_kind = BK_NONE;
        if (io_bus.i_ins_valid) begin
            case (io_bus.i_branch_control_signal)
                BC_REG: begin
                    case (io_bus.i_ins_func_code)
                        FN_BR:   w_kind = BK_BR;
                        FN_BLTZ: w_kind = r_flags[FLAG_N] ? BK_JUMP : BK_NONE;
                        FN_BZ:   w_kind = r_flags[FLAG_Z] ? BK_JUMP : BK_NONE;
                        FN_BNZ:  w_kind = r_flags[FLAG_Z] ? BK_NONE : BK_JUMP;
                        default: w_kind = BK_NONE;
                    endcase
                end
                BC_UNC: begin
                    case (io_bus.i_ins_func_code)
                        FN_B:    w_kind = BK_JUMP;
                        FN_BCY:  w_kind = r_flags[FLAG_C] ? BK_JUMP : BK_NONE;
                        FN_BNCY: w_kind = r_flags[FLAG_C] ? BK_NONE : BK_JUMP;
                        default: w_kind = BK_NONE;
                    endcase
                end
                BC_BL:   w_kind = BK_BL;
                BC_NONE: w_kind = BK_NONE;
            endcase
        end
    end

    assign w_taken   = (w_kind != BK_NONE);
    assign w_ref     = r_pc + ADDR_W'(1);
    assign w_next_pc = (w_kind == BK_BR) ? io_bus.i_reg1 :
                       w_taken           ? io_bus.i_dest_addr : w_ref;
    assign w_push    = !io_bus.i_stall && (w_kind == BK_BL);
    assign w_pop     = !io_bus.i_stall && (w_kind == BK_BR);

    branch_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ref),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else if (!io_bus.i_stall) begin
            r_pc <= w_next_pc;
            if (io_bus.i_flag_we) r_flags <= io_bus.i_alu_flag;
            if (w_taken && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign io_bus.o_pc_out      = r_pc;
    assign io_bus.o_ref         = w_ref;
    assign io_bus.o_taken       = w_taken;
    assign io_bus.o_ras_top     = w_ras_top;
    assign io_bus.o_ras_empty   = w_ras_empty;
    assign io_bus.o_ras_full    = w_ras_full;
    assign io_bus.o_ras_hit     = (w_kind == BK_BR) && !w_ras_empty && (w_ras_top == io_bus.i_reg1);
    assign io_bus.o_taken_count = r_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed scenarios plus random traffic against a
// queue-based reference model; a second instance uses a 2-bit counter.
module tb_branch_pc_unit;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned CNT2_W    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W))  bus  ();
    branch_pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT2_W)) bus2 ();

    branch_pc_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk), .rst (rst), .io_bus (bus)
    );

    branch_pc_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT2_W)) u_dut2 (
        .clk (clk), .rst (rst), .io_bus (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus as applied to u_dut, and the reference model state
    logic        s_st, s_v, s_fwe;
    logic [1:0]  s_bc;
    logic [5:0]  s_fn;
    logic [2:0]  s_alu;
    logic [31:0] s_dest, s_r1;
    logic [31:0] m_pc;
    logic [2:0]  m_flags;
    logic [31:0] m_ras [$];
    logic [15:0] m_cnt;
    logic        e_tk, e_br, e_bl;
    logic [31:0] e_tgt;

    task automatic drive(input logic st, input logic v, input logic [1:0] bc, input logic [5:0] fn,
                         input logic [2:0] alu, input logic fwe, input logic [31:0] dest, input logic [31:0] r1);
        s_st = st; s_v = v; s_bc = bc; s_fn = fn; s_alu = alu; s_fwe = fwe; s_dest = dest; s_r1 = r1;
        bus.i_stall = st; bus.i_ins_valid = v; bus.i_branch_control_signal = bc; bus.i_ins_func_code = fn;
        bus.i_alu_flag = alu; bus.i_flag_we = fwe; bus.i_dest_addr = dest; bus.i_reg1 = r1;
    endtask

    task automatic drive2(input logic v, input logic [1:0] bc, input logic [5:0] fn, input logic [31:0] dest);
        bus2.i_stall = 1'b0; bus2.i_ins_valid = v; bus2.i_branch_control_signal = bc; bus2.i_ins_func_code = fn;
        bus2.i_alu_flag = 3'b000; bus2.i_flag_we = 1'b0; bus2.i_dest_addr = dest; bus2.i_reg1 = 32'h0;
    endtask

    task automatic mdl_reset();
        m_pc = 32'h0; m_flags = 3'b000; m_cnt = 16'h0; m_ras.delete();
    endtask

    // Mnemonic-level view of the instruction set against the model's flags {C,N,Z}
    task automatic mdl_decode();
        logic z, n, c;
        {c, n, z} = m_flags;
        e_tk = 1'b0; e_br = 1'b0; e_bl = 1'b0;
        if (s_v) begin
            if      (s_bc == 2'b00 && s_fn == 6'd0) begin e_br = 1'b1; e_tk = 1'b1; end
            else if (s_bc == 2'b00 && s_fn == 6'd1) e_tk = n;
            else if (s_bc == 2'b00 && s_fn == 6'd2) e_tk = z;
            else if (s_bc == 2'b00 && s_fn == 6'd3) e_tk = !z;
            else if (s_bc == 2'b01 && s_fn == 6'd0) e_tk = 1'b1;
            else if (s_bc == 2'b01 && s_fn == 6'd1) e_tk = c;
            else if (s_bc == 2'b01 && s_fn == 6'd2) e_tk = !c;
            else if (s_bc == 2'b10) begin e_bl = 1'b1; e_tk = 1'b1; end
        end
        e_tgt = e_br ? s_r1 : (e_tk ? s_dest : m_pc + 32'd1);
    endtask

    function automatic logic [31:0] mdl_top();
        return (m_ras.size() != 0) ? m_ras[$] : 32'h0;
    endfunction

    // Advance the model over the driven instruction, then cross one clock edge
    task automatic step();
        mdl_decode();
        if (!s_st) begin
            if (e_bl) begin
                m_ras.push_back(m_pc + 32'd1);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
            if (e_br && m_ras.size() != 0) void'(m_ras.pop_back());
            if (e_tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (s_fwe) m_flags = s_alu;
            m_pc = e_tgt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b11, 6'd0, 3'b000, 1'b0, 32'h0, 32'h0);
        drive2(1'b0, 2'b11, 6'd0, 32'h0);
        #2;
        n_checks++; if (bus.o_pc_out !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", bus.o_pc_out); end
        n_checks++; if (bus.o_ras_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ras_empty: got %b want 1", bus.o_ras_empty); end
        n_checks++; if (bus2.o_taken_count !== 2'd0) begin n_errors++; $display("FAIL reset_count2: got %0d want 0", bus2.o_taken_count); end
        @(negedge clk); rst = 1'b0; mdl_reset();
        drive(1'b0, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'h1234, 32'h0); step();
        drive(1'b0, 1'b1, 2'b10, 6'd5, 3'b000, 1'b0, 32'h50, 32'h0); step();
        n_checks++; if (bus.o_pc_out !== 32'h50) begin n_errors++; $display("FAIL pre_reset_pc: got %h want 50", bus.o_pc_out); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.o_pc_out !== 32'h0) begin n_errors++; $display("FAIL midreset_pc: got %h want 0", bus.o_pc_out); end
        n_checks++; if (bus.o_ras_empty !== 1'b1) begin n_errors++; $display("FAIL midreset_ras_empty: got %b want 1", bus.o_ras_empty); end
        n_checks++; if (bus.o_taken_count !== 16'd0) begin n_errors++; $display("FAIL midreset_count: got %0d want 0", bus.o_taken_count); end
        @(negedge clk); rst = 1'b0; mdl_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 2'b11, 6'd0, 3'b000, 1'b0, 32'h0, 32'h0); step();
            n_checks++; if (bus.o_pc_out !== 32'(k)) begin n_errors++; $display("FAIL nop_pc%0d: got %h want %h", k, bus.o_pc_out, 32'(k)); end
        end
    endtask

    task automatic test_flags();
        drive(1'b0, 1'b1, 2'b00, 6'd2, 3'b001, 1'b1, 32'h40, 32'h0);
        #1;
        n_checks++; if (bus.o_taken !== 1'b0) begin n_errors++; $display("FAIL bz_old_flags_taken: got %b want 0", bus.o_taken); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h4) begin n_errors++; $display("FAIL bz_old_flags_pc: got %h want 4", bus.o_pc_out); end
        drive(1'b0, 1'b1, 2'b00, 6'd3, 3'b000, 1'b0, 32'h77, 32'h0);
        #1;
        n_checks++; if (bus.o_taken !== 1'b0) begin n_errors++; $display("FAIL bnz_z_set_taken: got %b want 0", bus.o_taken); end
        step();
        drive(1'b0, 1'b1, 2'b00, 6'd2, 3'b000, 1'b0, 32'h40, 32'h0);
        #1;
        n_checks++; if (bus.o_taken !== 1'b1) begin n_errors++; $display("FAIL bz_new_flags_taken: got %b want 1", bus.o_taken); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h40) begin n_errors++; $display("FAIL bz_new_flags_pc: got %h want 40", bus.o_pc_out); end
    endtask

    task automatic test_ras_pair();
        drive(1'b0, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'h10, 32'h0); step();
        drive(1'b0, 1'b1, 2'b10, 6'd9, 3'b000, 1'b0, 32'h80, 32'h0);
        #1;
        n_checks++; if (bus.o_ref !== 32'h11) begin n_errors++; $display("FAIL bl_ref: got %h want 11", bus.o_ref); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h80) begin n_errors++; $display("FAIL bl_pc: got %h want 80", bus.o_pc_out); end
        n_checks++; if (bus.o_ras_top !== 32'h11) begin n_errors++; $display("FAIL bl_ras_top: got %h want 11", bus.o_ras_top); end
        drive(1'b0, 1'b1, 2'b00, 6'd0, 3'b000, 1'b0, 32'h0, 32'h11);
        #1;
        n_checks++; if (bus.o_ras_hit !== 1'b1) begin n_errors++; $display("FAIL br_ras_hit: got %b want 1", bus.o_ras_hit); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h11) begin n_errors++; $display("FAIL br_pc: got %h want 11", bus.o_pc_out); end
        n_checks++; if (bus.o_ras_empty !== 1'b1) begin n_errors++; $display("FAIL br_ras_empty: got %b want 1", bus.o_ras_empty); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] ret;
        drive(1'b0, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'h1, 32'h0); step();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 2'b10, 6'd0, 3'b000, 1'b0, 32'(i + 1), 32'h0); step();
        end
        n_checks++; if (bus.o_ras_full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b want 1", bus.o_ras_full); end
        for (int i = 0; i < 4; i++) begin
            ret = 32'(6 - i);
            drive(1'b0, 1'b1, 2'b00, 6'd0, 3'b000, 1'b0, 32'h0, ret);
            #1;
            n_checks++; if (bus.o_ras_top !== ret) begin n_errors++; $display("FAIL ovf_pop%0d_top: got %h want %h", i, bus.o_ras_top, ret); end
            n_checks++; if (bus.o_ras_hit !== 1'b1) begin n_errors++; $display("FAIL ovf_pop%0d_hit: got %b want 1", i, bus.o_ras_hit); end
            step();
            n_checks++; if (bus.o_pc_out !== ret) begin n_errors++; $display("FAIL ovf_pop%0d_pc: got %h want %h", i, bus.o_pc_out, ret); end
        end
        drive(1'b0, 1'b1, 2'b00, 6'd0, 3'b000, 1'b0, 32'h0, 32'h99);
        #1;
        n_checks++; if (bus.o_ras_hit !== 1'b0) begin n_errors++; $display("FAIL empty_br_hit: got %b want 0", bus.o_ras_hit); end
        n_checks++; if (bus.o_ras_top !== 32'h0) begin n_errors++; $display("FAIL empty_br_top: got %h want 0", bus.o_ras_top); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h99) begin n_errors++; $display("FAIL empty_br_pc: got %h want 99", bus.o_pc_out); end
        n_checks++; if (bus.o_ras_empty !== 1'b1) begin n_errors++; $display("FAIL empty_br_empty: got %b want 1", bus.o_ras_empty); end
    endtask

    task automatic test_stall();
        logic [15:0] cnt0;
        cnt0 = m_cnt;
        drive(1'b1, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'h20, 32'h0);
        #1;
        n_checks++; if (bus.o_taken !== 1'b1) begin n_errors++; $display("FAIL stall_taken: got %b want 1", bus.o_taken); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h99) begin n_errors++; $display("FAIL stall_pc: got %h want 99", bus.o_pc_out); end
        n_checks++; if (bus.o_taken_count !== cnt0) begin n_errors++; $display("FAIL stall_count: got %0d want %0d", bus.o_taken_count, cnt0); end
        drive(1'b1, 1'b1, 2'b10, 6'd0, 3'b000, 1'b0, 32'h70, 32'h0); step();
        n_checks++; if (bus.o_ras_empty !== 1'b1) begin n_errors++; $display("FAIL stall_bl_ras: got %b want 1", bus.o_ras_empty); end
        drive(1'b0, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'h20, 32'h0); step();
        n_checks++; if (bus.o_pc_out !== 32'h20) begin n_errors++; $display("FAIL unstall_pc: got %h want 20", bus.o_pc_out); end
        n_checks++; if (bus.o_taken_count !== cnt0 + 16'd1) begin n_errors++; $display("FAIL unstall_count: got %0d want %0d", bus.o_taken_count, cnt0 + 16'd1); end
    endtask

    task automatic test_wrap_undef();
        drive(1'b0, 1'b1, 2'b01, 6'd0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0); step();
        drive(1'b0, 1'b1, 2'b11, 6'd0, 3'b000, 1'b0, 32'h55, 32'h0);
        #1;
        n_checks++; if (bus.o_ref !== 32'h0) begin n_errors++; $display("FAIL wrap_ref: got %h want 0", bus.o_ref); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h0) begin n_errors++; $display("FAIL wrap_pc: got %h want 0", bus.o_pc_out); end
        drive(1'b0, 1'b1, 2'b00, 6'd7, 3'b000, 1'b0, 32'h55, 32'h55);
        #1;
        n_checks++; if (bus.o_taken !== 1'b0) begin n_errors++; $display("FAIL undef_taken: got %b want 0", bus.o_taken); end
        step();
        n_checks++; if (bus.o_pc_out !== 32'h1) begin n_errors++; $display("FAIL undef_pc: got %h want 1", bus.o_pc_out); end
        drive(1'b0, 1'b1, 2'b01, 6'd3, 3'b000, 1'b0, 32'h55, 32'h0); step();
        n_checks++; if (bus.o_pc_out !== 32'h2) begin n_errors++; $display("FAIL undef_unc_pc: got %h want 2", bus.o_pc_out); end
    endtask

    task automatic test_count_sat();
        logic [1:0] exp;
        drive(1'b0, 1'b0, 2'b11, 6'd0, 3'b000, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            drive2(1'b1, 2'b01, 6'd0, 32'h5);
            step();
            exp = (k > 3) ? 2'd3 : 2'(k);
            n_checks++; if (bus2.o_taken_count !== exp) begin n_errors++; $display("FAIL count2_sat%0d: got %0d want %0d", k, bus2.o_taken_count, exp); end
        end
        drive2(1'b0, 2'b11, 6'd0, 32'h0);
    endtask

    task automatic test_random();
        logic [5:0] fn_tab [5];
        logic [1:0] bc;
        logic [5:0] fn;
        logic [31:0] r1;
        logic hit;
        fn_tab[0] = 6'd0; fn_tab[1] = 6'd1; fn_tab[2] = 6'd2; fn_tab[3] = 6'd3; fn_tab[4] = 6'd7;
        for (int i = 0; i < 400; i++) begin
            bc = 2'($urandom_range(0, 3));
            fn = fn_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) begin bc = 2'b00; fn = 6'd0; end
            r1 = ($urandom_range(0, 1) == 1) ? mdl_top() : $urandom;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, bc, fn,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, r1);
            #1;
            mdl_decode();
            hit = e_br && (m_ras.size() != 0) && (m_ras[$] == s_r1);
            n_checks++; if (bus.o_taken !== e_tk) begin n_errors++; $display("FAIL rnd%0d_taken: got %b want %b", i, bus.o_taken, e_tk); end
            n_checks++; if (bus.o_ref !== m_pc + 32'd1) begin n_errors++; $display("FAIL rnd%0d_ref: got %h want %h", i, bus.o_ref, m_pc + 32'd1); end
            n_checks++; if (bus.o_ras_hit !== hit) begin n_errors++; $display("FAIL rnd%0d_hit: got %b want %b", i, bus.o_ras_hit, hit); end
            step();
            n_checks++; if (bus.o_pc_out !== m_pc) begin n_errors++; $display("FAIL rnd%0d_pc: got %h want %h", i, bus.o_pc_out, m_pc); end
            n_checks++; if (bus.o_ras_top !== mdl_top()) begin n_errors++; $display("FAIL rnd%0d_top: got %h want %h", i, bus.o_ras_top, mdl_top()); end
            n_checks++; if (bus.o_ras_empty !== (m_ras.size() == 0)) begin n_errors++; $display("FAIL rnd%0d_empty: got %b want %b", i, bus.o_ras_empty, m_ras.size() == 0); end
            n_checks++; if (bus.o_taken_count !== m_cnt) begin n_errors++; $display("FAIL rnd%0d_count: got %0d want %0d", i, bus.o_taken_count, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_ras_pair();
        test_ras_overflow();
        test_stall();
        test_wrap_undef();
        test_count_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
